dpram_param: RTL and testbench

Parametrised true dual-port RAM that implements the storage behind the team's `dpram_if` bench interface. Two independent read/write ports share one clock. The block adds byte enables, a configurable read latency and cross-port collision resolution. After every reset it runs a self-clearing initialisation sweep, so the memory contents are known before traffic is accepted.

---
 rtl/dpram_pkg.sv | 17 +
 rtl/dpram_rd_pipe.sv | 41 ++++
 rtl/dpram_param.sv | 139 +++++++++++++
 tb/tb_dpram_param.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_pkg.sv
// rtl/dpram_pkg.sv - shared types and limits for the parametrised dual-port RAM
package dpram_pkg;

  typedef enum logic {
    READ_FIRST  = 1'b0,
    WRITE_FIRST = 1'b1
  } coll_mode_e;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } dpram_state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

endpackage

// File: rtl/dpram_rd_pipe.sv
// rtl/dpram_rd_pipe.sv - read latency shift register for one RAM port
module dpram_rd_pipe #(
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic [RD_LAT-1:0] vld;
  logic [DATA_W-1:0] dat [RD_LAT];

  // Data stages only load behind a valid, so the output word holds between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        dat[i] <= '0;
      end
    end else begin
      vld[0] <= in_valid;
      if (in_valid) begin
        dat[0] <= in_data;
      end
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) begin
          dat[i] <= dat[i-1];
        end
      end
    end
  end

  assign out_valid = vld[RD_LAT-1];
  assign out_data  = dat[RD_LAT-1];

endmodule

// File: rtl/dpram_param.sv
// rtl/dpram_param.sv - true dual-port RAM with byte enables, read latency,
// collision handling and a post-reset initialisation sweep
module dpram_param
  import dpram_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 256,
  parameter int                RD_LAT    = 1,
  parameter int                COLL_MODE = 0,
  parameter logic [DATA_W-1:0] INIT_VAL  = '0,
  localparam int               ADDR_W    = $clog2(DEPTH),
  localparam int               BE_W      = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_en,
  input  logic              a_wr,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic [BE_W-1:0]   a_be,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rvalid,
  input  logic              b_en,
  input  logic              b_wr,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic [BE_W-1:0]   b_be,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid,
  output logic              init_done,
  output logic              coll_err
);

  if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_data_w
    $error("dpram_param: DATA_W must be a non-zero multiple of 8");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("dpram_param: DEPTH must be a power of two >= 2");
  end
  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("dpram_param: RD_LAT must be 1 or 2");
  end
  if (COLL_MODE != 0 && COLL_MODE != 1) begin : g_bad_coll_mode
    $error("dpram_param: COLL_MODE must be 0 or 1");
  end

  dpram_state_e      state;
  logic [ADDR_W-1:0] init_cnt;
  logic              run;
  logic              a_we, a_re, b_we, b_re, same_addr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] a_rd_word, b_rd_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_INIT;
      init_cnt <= '0;
    end else if (state == S_INIT) begin
      init_cnt <= init_cnt + ADDR_W'(1);
      if (init_cnt == ADDR_W'(DEPTH - 1)) begin
        state <= S_RUN;
      end
    end
  end

  assign run       = (state == S_RUN);
  assign init_done = run;

  // Requests arriving during the sweep are dropped here, before any side effect.
  assign a_we      = run & a_en & a_wr;
  assign a_re      = run & a_en & ~a_wr;
  assign b_we      = run & b_en & b_wr;
  assign b_re      = run & b_en & ~b_wr;
  assign same_addr = (a_addr == b_addr);

  // Port A is written last so it owns any byte both ports enable.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[init_cnt] <= INIT_VAL;
    end else begin
      for (int i = 0; i < BE_W; i++) begin
        if (b_we && b_be[i]) begin
          mem[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
        end
        if (a_we && a_be[i]) begin
          mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    a_rd_word = mem[a_addr];
    b_rd_word = mem[b_addr];
    if (COLL_MODE == int'(WRITE_FIRST) && same_addr) begin
      for (int i = 0; i < BE_W; i++) begin
        if (b_we && b_be[i]) begin
          a_rd_word[8*i +: 8] = b_wdata[8*i +: 8];
        end
        if (a_we && a_be[i]) begin
          b_rd_word[8*i +: 8] = a_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coll_err <= 1'b0;
    end else begin
      coll_err <= a_we & b_we & same_addr;
    end
  end

  dpram_rd_pipe #(
    .DATA_W(DATA_W),
    .RD_LAT(RD_LAT)
  ) u_a_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (a_re),
    .in_data  (a_rd_word),
    .out_valid(a_rvalid),
    .out_data (a_rdata)
  );

  dpram_rd_pipe #(
    .DATA_W(DATA_W),
    .RD_LAT(RD_LAT)
  ) u_b_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (b_re),
    .in_data  (b_rd_word),
    .out_valid(b_rvalid),
    .out_data (b_rdata)
  );

endmodule

// File: tb/tb_dpram_param.sv
// tb/tb_dpram_param.sv - directed bench: u0 is RD_LAT=1 read-first, u1 is RD_LAT=2 write-first
module tb_dpram_param;

  localparam logic [31:0] IV = 32'hA5A5A5A5;

  logic        clk, rst;
  logic        a_en, a_wr, b_en, b_wr;
  logic [3:0]  a_addr, b_addr, a_be, b_be;
  logic [31:0] a_wdata, b_wdata;
  logic [31:0] a_rdata0, b_rdata0, a_rdata1, b_rdata1;
  logic        a_rvalid0, b_rvalid0, a_rvalid1, b_rvalid1;
  logic        init_done0, init_done1, coll_err0, coll_err1;

  int n_cmp = 0;
  int n_err = 0;

  dpram_param #(.DATA_W(32), .DEPTH(16), .RD_LAT(1), .COLL_MODE(0), .INIT_VAL(IV)) u0 (
    .clk(clk), .rst(rst),
    .a_en(a_en), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
    .a_rdata(a_rdata0), .a_rvalid(a_rvalid0),
    .b_en(b_en), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
    .b_rdata(b_rdata0), .b_rvalid(b_rvalid0),
    .init_done(init_done0), .coll_err(coll_err0)
  );

  dpram_param #(.DATA_W(32), .DEPTH(16), .RD_LAT(2), .COLL_MODE(1), .INIT_VAL(IV)) u1 (
    .clk(clk), .rst(rst),
    .a_en(a_en), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
    .a_rdata(a_rdata1), .a_rvalid(a_rvalid1),
    .b_en(b_en), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
    .b_rdata(b_rdata1), .b_rvalid(b_rvalid1),
    .init_done(init_done1), .coll_err(coll_err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        a_en, a_wr;
    logic [3:0]  a_addr;
    logic [31:0] a_wdata;
    logic [3:0]  a_be;
    logic        b_en, b_wr;
    logic [3:0]  b_addr;
    logic [31:0] b_wdata;
    logic [3:0]  b_be;
    logic [31:0] exp_a0, exp_a1, exp_b0, exp_b1;
    logic        exp_coll;
  } vec_t;

  vec_t tbl [15];

  function automatic vec_t mkv(input string nm,
                               input logic ae, input logic aw, input logic [3:0] aa,
                               input logic [31:0] ad, input logic [3:0] abe,
                               input logic be_, input logic bw, input logic [3:0] ba,
                               input logic [31:0] bd, input logic [3:0] bbe,
                               input logic [31:0] ea0, input logic [31:0] ea1,
                               input logic [31:0] eb0, input logic [31:0] eb1,
                               input logic ec);
    vec_t v;
    v.name = nm;
    v.a_en = ae; v.a_wr = aw; v.a_addr = aa; v.a_wdata = ad; v.a_be = abe;
    v.b_en = be_; v.b_wr = bw; v.b_addr = ba; v.b_wdata = bd; v.b_be = bbe;
    v.exp_a0 = ea0; v.exp_a1 = ea1; v.exp_b0 = eb0; v.exp_b1 = eb1;
    v.exp_coll = ec;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    a_en = 0; a_wr = 0; a_addr = 0; a_wdata = 0; a_be = 0;
    b_en = 0; b_wr = 0; b_addr = 0; b_wdata = 0; b_be = 0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply(input vec_t v);
    logic arv, brv;
    arv = v.a_en & ~v.a_wr;
    brv = v.b_en & ~v.b_wr;
    a_en = v.a_en; a_wr = v.a_wr; a_addr = v.a_addr; a_wdata = v.a_wdata; a_be = v.a_be;
    b_en = v.b_en; b_wr = v.b_wr; b_addr = v.b_addr; b_wdata = v.b_wdata; b_be = v.b_be;
    step();
    idle();
    chk({v.name, "/a_rv0"}, {31'b0, a_rvalid0}, {31'b0, arv});
    chk({v.name, "/b_rv0"}, {31'b0, b_rvalid0}, {31'b0, brv});
    chk({v.name, "/a_rv1_early"}, {31'b0, a_rvalid1}, 32'd0);
    chk({v.name, "/b_rv1_early"}, {31'b0, b_rvalid1}, 32'd0);
    if (arv) chk({v.name, "/a_rd0"}, a_rdata0, v.exp_a0);
    if (brv) chk({v.name, "/b_rd0"}, b_rdata0, v.exp_b0);
    chk({v.name, "/coll0"}, {31'b0, coll_err0}, {31'b0, v.exp_coll});
    chk({v.name, "/coll1"}, {31'b0, coll_err1}, {31'b0, v.exp_coll});
    step();
    chk({v.name, "/a_rv1"}, {31'b0, a_rvalid1}, {31'b0, arv});
    chk({v.name, "/b_rv1"}, {31'b0, b_rvalid1}, {31'b0, brv});
    chk({v.name, "/a_rv0_late"}, {31'b0, a_rvalid0}, 32'd0);
    chk({v.name, "/b_rv0_late"}, {31'b0, b_rvalid0}, 32'd0);
    if (arv) chk({v.name, "/a_rd1"}, a_rdata1, v.exp_a1);
    if (brv) chk({v.name, "/b_rd1"}, b_rdata1, v.exp_b1);
    if (arv) chk({v.name, "/a_rd0_hold"}, a_rdata0, v.exp_a0);
    chk({v.name, "/coll0_once"}, {31'b0, coll_err0}, 32'd0);
    chk({v.name, "/coll1_once"}, {31'b0, coll_err1}, 32'd0);
  endtask

  // k-th pulse must land on iteration k+lat-1: checks latency, order and no gaps together.
  task automatic chk_pulse(input string nm, input logic v, input logic [31:0] d, input int it,
                           input int lat, input logic [31:0] base, input logic [31:0] stp,
                           input logic rev, inout int k);
    logic [31:0] idx;
    if (v) begin
      idx = rev ? 32'(15 - k) : 32'(k);
      chk($sformatf("%s/pos%0d", nm, k), 32'(it), 32'(k + lat - 1));
      chk($sformatf("%s/data%0d", nm, k), d, base + idx * stp);
      k++;
    end
  endtask

  // Port A reads 0..15 ascending while port B reads 15..0, back to back.
  task automatic stream(input string nm, input logic [31:0] base, input logic [31:0] stp);
    int ka0, kb0, ka1, kb1;
    ka0 = 0; kb0 = 0; ka1 = 0; kb1 = 0;
    for (int it = 0; it < 19; it++) begin
      if (it < 16) begin
        a_en = 1; a_wr = 0; a_addr = 4'(it);
        b_en = 1; b_wr = 0; b_addr = 4'(15 - it);
      end else begin
        idle();
      end
      step();
      chk_pulse({nm, "/a0"}, a_rvalid0, a_rdata0, it, 1, base, stp, 1'b0, ka0);
      chk_pulse({nm, "/b0"}, b_rvalid0, b_rdata0, it, 1, base, stp, 1'b1, kb0);
      chk_pulse({nm, "/a1"}, a_rvalid1, a_rdata1, it, 2, base, stp, 1'b0, ka1);
      chk_pulse({nm, "/b1"}, b_rvalid1, b_rdata1, it, 2, base, stp, 1'b1, kb1);
    end
    chk({nm, "/cnt_a0"}, 32'(ka0), 32'd16);
    chk({nm, "/cnt_b0"}, 32'(kb0), 32'd16);
    chk({nm, "/cnt_a1"}, 32'(ka1), 32'd16);
    chk({nm, "/cnt_b1"}, 32'(kb1), 32'd16);
  endtask

  // Counts cycles from reset release to init_done, with port traffic during the first few.
  task automatic wait_init(input string nm);
    int cyc, rv_seen;
    cyc = 0; rv_seen = 0;
    a_en = 1; a_wr = 0; a_addr = 0;
    b_en = 1; b_wr = 1; b_addr = 4'd1; b_wdata = 32'h0; b_be = 4'hF;
    while (!init_done0 && cyc < 64) begin
      if (cyc == 8) idle();
      step();
      cyc++;
      if (a_rvalid0 | b_rvalid0 | a_rvalid1 | b_rvalid1) rv_seen++;
    end
    chk({nm, "/init_cycles"}, 32'(cyc), 32'd16);
    chk({nm, "/init_done1"}, {31'b0, init_done1}, 32'd1);
    chk({nm, "/no_rv_in_init"}, 32'(rv_seen), 32'd0);
  endtask

  initial begin
    int rv_seen;
    tbl[0]  = mkv("be_write", 1,1,4'd3,32'h11223344,4'b0101, 0,0,4'd0,32'h0,4'h0, 0,0,0,0, 0);
    tbl[1]  = mkv("be_read",  1,0,4'd3,32'h0,4'h0, 1,0,4'd3,32'h0,4'h0,
                  32'hA522A544,32'hA522A544,32'hA522A544,32'hA522A544, 0);
    tbl[2]  = mkv("clr5",     1,1,4'd5,32'h0,4'hF, 0,0,4'd0,32'h0,4'h0, 0,0,0,0, 0);
    tbl[3]  = mkv("coll_rw",  1,1,4'd5,32'hDEADBEEF,4'hF, 1,0,4'd5,32'h0,4'h0,
                  0,0,32'h0,32'hDEADBEEF, 0);
    tbl[4]  = mkv("rd5",      1,0,4'd5,32'h0,4'h0, 0,0,4'd0,32'h0,4'h0,
                  32'hDEADBEEF,32'hDEADBEEF,0,0, 0);
    tbl[5]  = mkv("coll_ww",  1,1,4'd7,32'h000000AA,4'b0001, 1,1,4'd7,32'hBBBBBB00,4'b1111,
                  0,0,0,0, 1);
    tbl[6]  = mkv("rd7",      1,0,4'd7,32'h0,4'h0, 1,0,4'd7,32'h0,4'h0,
                  32'hBBBBBBAA,32'hBBBBBBAA,32'hBBBBBBAA,32'hBBBBBBAA, 0);
    tbl[7]  = mkv("coll_wr_b",1,0,4'd9,32'h0,4'h0, 1,1,4'd9,32'hCAFEF00D,4'b1100,
                  IV,32'hCAFEA5A5,0,0, 0);
    tbl[8]  = mkv("rd9",      1,0,4'd9,32'h0,4'h0, 1,0,4'd9,32'h0,4'h0,
                  32'hCAFEA5A5,32'hCAFEA5A5,32'hCAFEA5A5,32'hCAFEA5A5, 0);
    tbl[9]  = mkv("be_zero",  1,1,4'd2,32'h12345678,4'h0, 0,0,4'd0,32'h0,4'h0, 0,0,0,0, 0);
    tbl[10] = mkv("rd2",      1,0,4'd2,32'h0,4'h0, 0,0,4'd0,32'h0,4'h0, IV,IV,0,0, 0);
    tbl[11] = mkv("ww_diff",  1,1,4'd10,32'h01010101,4'hF, 1,1,4'd11,32'h02020202,4'hF,
                  0,0,0,0, 0);
    tbl[12] = mkv("rd10_11",  1,0,4'd10,32'h0,4'h0, 1,0,4'd11,32'h0,4'h0,
                  32'h01010101,32'h01010101,32'h02020202,32'h02020202, 0);
    tbl[13] = mkv("ww_disj",  1,1,4'd4,32'h00001111,4'b0011, 1,1,4'd4,32'h22220000,4'b1100,
                  0,0,0,0, 1);
    tbl[14] = mkv("rd4",      1,0,4'd4,32'h0,4'h0, 0,0,4'd0,32'h0,4'h0,
                  32'h22221111,32'h22221111,0,0, 0);

    rst = 1;
    idle();
    repeat (3) @(negedge clk);
    chk("rst/a_rdata0", a_rdata0, 32'd0);
    chk("rst/b_rdata1", b_rdata1, 32'd0);
    chk("rst/rvalid", {28'b0, a_rvalid0, b_rvalid0, a_rvalid1, b_rvalid1}, 32'd0);
    chk("rst/init_done", {30'b0, init_done0, init_done1}, 32'd0);
    chk("rst/coll_err", {30'b0, coll_err0, coll_err1}, 32'd0);
    rst = 0;
    wait_init("init");
    stream("init_rd", IV, 32'd0);

    for (int i = 0; i < 15; i++) apply(tbl[i]);

    // same-port read the cycle after a write to that address
    a_en = 1; a_wr = 1; a_addr = 4'd12; a_wdata = 32'h77777777; a_be = 4'hF;
    step();
    a_wr = 0;
    step();
    idle();
    chk("raw/a_rv0", {31'b0, a_rvalid0}, 32'd1);
    chk("raw/a_rd0", a_rdata0, 32'h77777777);
    step();
    chk("raw/a_rv1", {31'b0, a_rvalid1}, 32'd1);
    chk("raw/a_rd1", a_rdata1, 32'h77777777);

    for (int k = 0; k < 16; k++) begin
      a_en = 1; a_wr = 1; a_addr = 4'(k); a_wdata = 32'hF00D0000 + 32'(k); a_be = 4'hF;
      step();
    end
    idle();
    stream("fill_rd", 32'hF00D0000, 32'd1);

    // reset one cycle into a read: nothing may come out, sweep must rerun
    a_en = 1; a_wr = 0; a_addr = 4'd3;
    b_en = 1; b_wr = 0; b_addr = 4'd3;
    @(posedge clk);
    #1 rst = 1;
    idle();
    rv_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (a_rvalid0 | b_rvalid0 | a_rvalid1 | b_rvalid1) rv_seen++;
    end
    chk("mid_rst/no_rvalid", 32'(rv_seen), 32'd0);
    chk("mid_rst/init_drop", {30'b0, init_done0, init_done1}, 32'd0);
    rst = 0;
    wait_init("mid_rst");
    a_en = 1; a_wr = 0; a_addr = 4'd3;
    step();
    idle();
    chk("mid_rst/reinit_rv0", {31'b0, a_rvalid0}, 32'd1);
    chk("mid_rst/reinit_rd0", a_rdata0, IV);
    step();
    chk("mid_rst/reinit_rd1", a_rdata1, IV);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
